// File: rtl/alarm_ctrl.sv
// Arm/disarm/trigger controller: conditions the IR sense input, runs exit, hold and lockout timers, checks the passcode.
// Motion-to-state latency is DEBOUNCE_CYC+4 edges; there is no backpressure, and all outputs are registered or decoded from registers.
module alarm_ctrl #(
  parameter int         CLK_HZ        = 50_000_000,
  parameter int         DEBOUNCE_CYC  = 500_000,
  parameter int         EXIT_DELAY_S  = 10,
  parameter int         ALARM_HOLD_S  = 60,
  parameter int         LOCKOUT_S     = 30,
  parameter int         MAX_TRIES     = 3,
  parameter logic [9:0] SHUTDOWN_CODE = 10'h112
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSENSE,
  input  logic [9:0] iSW,
  input  logic       iARM,
  input  logic       iENTER,
  output logic       oVideo_On,
  output logic       oAlarm,
  output logic       oArmed,
  output logic [2:0] oState,
  output logic [7:0] oSecs_Left,
  output logic [2:0] oFails,
  output logic       oTick
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]    EXIT_S8   = 8'(EXIT_DELAY_S);
  localparam logic [7:0]    HOLD_S8   = 8'(ALARM_HOLD_S);
  localparam logic [7:0]    LOCK_S8   = 8'(LOCKOUT_S);
  localparam logic [2:0]    TRIES3    = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ALARM    = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  logic          sync1, sync2, deb, deb_d, motion_pre, motion;
  logic [DW-1:0] db_cnt;
  logic [PW-1:0] pre_cnt;
  logic          arm_q, arm_d, enter_q, enter_d;
  logic          tick, arm_p, enter_p, code_ok;
  state_t        state;
  logic [7:0]    secs;
  logic [2:0]    fails, fails_inc;
  logic          video, alarm, armed;

  // Sense path: 2-FF sync, stability counter, then a two-stage edge pipeline.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      deb        <= 1'b0;
      deb_d      <= 1'b0;
      db_cnt     <= '0;
      motion_pre <= 1'b0;
      motion     <= 1'b0;
    end else begin
      sync1 <= iSENSE;
      sync2 <= sync1;
      if (sync2 != deb) begin
        if (db_cnt == DB_LAST) begin
          deb    <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      deb_d      <= deb;
      motion_pre <= deb ^ deb_d;
      motion     <= motion_pre;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pre_cnt <= '0;
      arm_q   <= 1'b0;
      arm_d   <= 1'b0;
      enter_q <= 1'b0;
      enter_d <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == TICK_LAST) ? '0 : pre_cnt + 1'b1;
      arm_q   <= iARM;
      arm_d   <= arm_q;
      enter_q <= iENTER;
      enter_d <= enter_q;
    end
  end

  assign tick      = (pre_cnt == TICK_LAST);
  assign arm_p     = arm_q & ~arm_d;
  assign enter_p   = enter_q & ~enter_d;
  assign code_ok   = (iSW == SHUTDOWN_CODE);
  assign fails_inc = (fails >= TRIES3) ? fails : fails + 3'd1;

  // Priority: code match > mismatch lockout > motion > tick.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_DISARMED;
      secs  <= 8'd0;
      fails <= 3'd0;
      video <= 1'b0;
      alarm <= 1'b0;
      armed <= 1'b0;
    end else begin
      case (state)
        ST_DISARMED: begin
          if (arm_p) begin
            state <= ST_EXIT;
            secs  <= EXIT_S8;
            armed <= 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (tick) begin
            if (secs == 8'd1) begin
              state <= ST_ARMED;
              secs  <= 8'd0;
              fails <= 3'd0;
              video <= 1'b0;
              alarm <= 1'b0;
            end else if (secs != 8'd0) begin
              secs <= secs - 8'd1;
            end
          end
        end
        ST_EXIT, ST_ARMED, ST_ALARM: begin
          if (enter_p && code_ok) begin
            state <= ST_DISARMED;
            secs  <= 8'd0;
            fails <= 3'd0;
            video <= 1'b0;
            alarm <= 1'b0;
            armed <= 1'b0;
          end else if (enter_p && fails_inc == TRIES3) begin
            state <= ST_LOCKOUT;
            secs  <= LOCK_S8;
            fails <= fails_inc;
            video <= 1'b1;
            alarm <= 1'b1;
          end else begin
            if (enter_p) fails <= fails_inc;
            if (state == ST_ARMED) begin
              if (motion) begin
                state <= ST_ALARM;
                secs  <= HOLD_S8;
                video <= 1'b1;
                alarm <= 1'b1;
              end
            end else if (state == ST_ALARM && motion) begin
              secs <= HOLD_S8;
            end else if (tick) begin
              if (secs == 8'd1) begin
                state <= ST_ARMED;
                secs  <= 8'd0;
                video <= 1'b0;
                alarm <= 1'b0;
              end else if (secs != 8'd0) begin
                secs <= secs - 8'd1;
              end
            end
          end
        end
        default: begin
          state <= ST_DISARMED;
          secs  <= 8'd0;
          fails <= 3'd0;
          video <= 1'b0;
          alarm <= 1'b0;
          armed <= 1'b0;
        end
      endcase
    end
  end

  assign oVideo_On  = video;
  assign oAlarm     = alarm;
  assign oArmed     = armed;
  assign oState     = state;
  assign oSecs_Left = secs;
  assign oFails     = fails;
  assign oTick      = tick;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with small timer parameters; cycle numbers count edges since reset release.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense;
  logic [9:0] sw;
  logic       arm;
  logic       enter;
  logic       video_on, alarm_o, armed_o, tick_o;
  logic [2:0] state_o, fails_o;
  logic [7:0] secs_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  alarm_ctrl #(
    .CLK_HZ(10), .DEBOUNCE_CYC(4), .EXIT_DELAY_S(2), .ALARM_HOLD_S(3),
    .LOCKOUT_S(2), .MAX_TRIES(3), .SHUTDOWN_CODE(10'h112)
  ) dut (
    .iCLK(clk), .iRST(rst), .iSENSE(sense), .iSW(sw), .iARM(arm), .iENTER(enter),
    .oVideo_On(video_on), .oAlarm(alarm_o), .oArmed(armed_o), .oState(state_o),
    .oSecs_Left(secs_o), .oFails(fails_o), .oTick(tick_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_secs"},  32'(secs_o),  32'd0);
    chk({tag, "_fails"}, 32'(fails_o), 32'd0);
    chk({tag, "_video"}, 32'(video_on), 32'd0);
    chk({tag, "_alarm"}, 32'(alarm_o), 32'd0);
    chk({tag, "_armed"}, 32'(armed_o), 32'd0);
    chk({tag, "_tick"},  32'(tick_o),  32'd0);
  endtask

  initial begin
    rst = 1'b1; sense = 1'b0; sw = 10'h000; arm = 1'b0; enter = 1'b0;
    #1;
    chk_all_zero("rst_hold");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk_all_zero("rst_rel");

    // Prescaler: tick in cycle 9, wraps in cycle 10.
    to_cyc(8);  chk("tick_c8",  32'(tick_o), 32'd0);
    to_cyc(9);  chk("tick_c9",  32'(tick_o), 32'd1);
    to_cyc(10); chk("tick_c10", 32'(tick_o), 32'd0);

    // Arm: pulse seen at edge 11, EXIT_DELAY from edge 12.
    arm = 1'b1;
    to_cyc(12);
    arm = 1'b0;
    chk("exit_state", 32'(state_o), 32'd1);
    chk("exit_secs",  32'(secs_o),  32'd2);
    chk("exit_armed", 32'(armed_o), 32'd1);
    // Sense toggles during exit delay must not alarm.
    sense = 1'b1;
    to_cyc(18); sense = 1'b0;
    to_cyc(20); chk("exit_secs_t1", 32'(secs_o), 32'd1);
    to_cyc(29);
    chk("exit_state_c29", 32'(state_o), 32'd1);
    chk("exit_video_c29", 32'(video_on), 32'd0);
    to_cyc(30);
    chk("armed_state", 32'(state_o), 32'd2);
    chk("armed_secs",  32'(secs_o),  32'd0);

    // Sense 0->1 sampled at edge 31 -> ALARM at edge 39.
    sense = 1'b1;
    to_cyc(38);
    chk("mot_state_c38", 32'(state_o), 32'd2);
    chk("mot_video_c38", 32'(video_on), 32'd0);
    to_cyc(39);
    chk("mot_state_c39", 32'(state_o), 32'd3);
    chk("mot_video_c39", 32'(video_on), 32'd1);
    chk("mot_alarm_c39", 32'(alarm_o), 32'd1);
    chk("mot_secs_c39",  32'(secs_o),  32'd3);
    to_cyc(59);
    chk("hold_secs_c59",  32'(secs_o),  32'd1);
    to_cyc(60);
    chk("hold_state_c60", 32'(state_o), 32'd2);
    chk("hold_video_c60", 32'(video_on), 32'd0);

    // Three-cycle glitch is filtered.
    sense = 1'b0;
    to_cyc(63); sense = 1'b1;
    to_cyc(75);
    chk("glitch3_state", 32'(state_o), 32'd2);
    chk("glitch3_video", 32'(video_on), 32'd0);
    // Four-cycle glitch: falling event in cycle 83 -> ALARM at edge 84.
    sense = 1'b0;
    to_cyc(79); sense = 1'b1;
    to_cyc(83); chk("glitch4_state_c83", 32'(state_o), 32'd2);
    to_cyc(84);
    chk("glitch4_state_c84", 32'(state_o), 32'd3);
    chk("glitch4_secs_c84",  32'(secs_o),  32'd3);
    to_cyc(100); chk("alarm_secs_c100", 32'(secs_o), 32'd1);

    // Motion in cycle 109 coincides with tick at secs==1: reload wins.
    to_cyc(101); sense = 1'b0;
    to_cyc(109);
    chk("reload_tick_c109", 32'(tick_o), 32'd1);
    chk("reload_secs_c109", 32'(secs_o), 32'd1);
    to_cyc(110);
    chk("reload_state", 32'(state_o), 32'd3);
    chk("reload_secs",  32'(secs_o),  32'd3);

    // Wrong code in ALARM, then right code disarms.
    sw = 10'h000; enter = 1'b1;
    to_cyc(111); enter = 1'b0;
    to_cyc(112);
    chk("alarm_bad_fails", 32'(fails_o), 32'd1);
    chk("alarm_bad_state", 32'(state_o), 32'd3);
    sw = 10'h112; enter = 1'b1;
    to_cyc(113); enter = 1'b0;
    to_cyc(114);
    chk("disarm_state", 32'(state_o), 32'd0);
    chk("disarm_video", 32'(video_on), 32'd0);
    chk("disarm_alarm", 32'(alarm_o), 32'd0);
    chk("disarm_fails", 32'(fails_o), 32'd0);
    chk("disarm_armed", 32'(armed_o), 32'd0);

    // Re-arm, reach ARMED at edge 130.
    arm = 1'b1;
    to_cyc(116); arm = 1'b0;
    chk("rearm_state", 32'(state_o), 32'd1);
    to_cyc(130); chk("rearm_armed_state", 32'(state_o), 32'd2);

    // Three wrong codes -> LOCKOUT.
    sw = 10'h000;
    enter = 1'b1; to_cyc(131); enter = 1'b0; to_cyc(132);
    chk("bad1_fails", 32'(fails_o), 32'd1);
    chk("bad1_state", 32'(state_o), 32'd2);
    enter = 1'b1; to_cyc(133); enter = 1'b0; to_cyc(134);
    chk("bad2_fails", 32'(fails_o), 32'd2);
    enter = 1'b1; to_cyc(135); enter = 1'b0; to_cyc(136);
    chk("lock_state", 32'(state_o), 32'd4);
    chk("lock_video", 32'(video_on), 32'd1);
    chk("lock_alarm", 32'(alarm_o), 32'd1);
    chk("lock_secs",  32'(secs_o),  32'd2);
    chk("lock_fails", 32'(fails_o), 32'd3);
    // Correct code ignored in LOCKOUT.
    sw = 10'h112; enter = 1'b1;
    to_cyc(137); enter = 1'b0;
    to_cyc(139);
    chk("lock_code_state", 32'(state_o), 32'd4);
    chk("lock_code_fails", 32'(fails_o), 32'd3);
    to_cyc(149); chk("lock_secs_c149", 32'(secs_o), 32'd1);
    to_cyc(150);
    chk("unlock_state", 32'(state_o), 32'd2);
    chk("unlock_fails", 32'(fails_o), 32'd0);
    chk("unlock_video", 32'(video_on), 32'd0);

    // Lock out again, then async reset mid-lockout.
    sw = 10'h000;
    enter = 1'b1; to_cyc(151); enter = 1'b0; to_cyc(152);
    enter = 1'b1; to_cyc(153); enter = 1'b0; to_cyc(154);
    enter = 1'b1; to_cyc(155); enter = 1'b0; to_cyc(156);
    chk("relock_state", 32'(state_o), 32'd4);
    to_cyc(158);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Arm/disarm and trigger controller for the surveillance path. It conditions the raw IR input, runs exit-delay, alarm-hold and lockout timers, and checks the switch passcode. It produces the video-enable level consumed by the video gating logic (decoder, SDRAM and VGA reset gating) in DE10_Standard_TV. It sits directly upstream of that gating and replaces its inline sense/passcode logic.

Parameters:
CLK_HZ, 50_000_000, iCLK frequency; the 1 Hz tick prescaler counts to this value.
DEBOUNCE_CYC, 500_000, consecutive stable cycles required before the debounced sense changes (>=1).
EXIT_DELAY_S, 10, seconds from arm to armed (1..255).
ALARM_HOLD_S, 60, seconds video stays on after the last motion event (1..255).
LOCKOUT_S, 30, seconds of forced alarm after too many wrong codes (1..255).
MAX_TRIES, 3, wrong code entries that cause lockout (1..7).
SHUTDOWN_CODE, 10'h112, disarm passcode on iSW.

Ports:
iCLK  in  1  system clock (CLOCK_50)
iRST  in  1  asynchronous active-high reset
iSENSE  in  1  raw IR sensor, asynchronous to iCLK
iSW  in  10  passcode switches, quasi-static
iARM  in  1  arm request, active-high level (inverted KEY); internally edge-detected
iENTER  in  1  code submit, active-high level; internally edge-detected
oVideo_On  out  1  video path enable
oAlarm  out  1  alarm indicator
oArmed  out  1  high in EXIT_DELAY, ARMED, ALARM and LOCKOUT
oState  out  3  current state encoding
oSecs_Left  out  8  remaining seconds of the active timer, 0 when no timer runs
oFails  out  3  wrong-code count
oTick  out  1  one-cycle 1 Hz strobe

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-timer. Resets all registers: state DISARMED, synchronizer 0, debounced sense 0, prescaler 0, secs 0, fails 0, edge registers 0. All outputs are 0 during and after reset until a transition occurs.
- Sense conditioning: 2-FF synchronizer, then a stability counter. The debounced sense takes the synchronized value once it has differed from the debounced value for DEBOUNCE_CYC consecutive cycles. Any mismatch gap restarts the count.
- A motion event is a one-cycle pulse on either edge of the debounced sense.
- Latency: if iSENSE changes and stays changed, the motion pulse is high in cycle DEBOUNCE_CYC+3 after the first iCLK edge that samples the new value. The state changes on the following edge.
- Tick: the prescaler counts 0..CLK_HZ-1 freely from reset. oTick is high in the cycle the count equals CLK_HZ-1, then the count wraps to 0.
- Edge detection: arm_p and enter_p are high for one cycle on a 0->1 transition of the registered input.
- Code check on enter_p: a match means iSW == SHUTDOWN_CODE.
- States (oState): DISARMED=0, EXIT_DELAY=1, ARMED=2, ALARM=3, LOCKOUT=4.
  - DISARMED: arm_p -> EXIT_DELAY with secs=EXIT_DELAY_S. enter_p is ignored, fails unchanged.
  - EXIT_DELAY: tick decrements secs; tick with secs==1 -> ARMED with secs=0. Motion is ignored.
  - ARMED: motion -> ALARM with secs=ALARM_HOLD_S.
  - ALARM: tick decrements secs; tick with secs==1 -> ARMED. Motion reloads secs=ALARM_HOLD_S; reload beats a simultaneous tick.
  - LOCKOUT: enter_p and arm_p are ignored. Tick decrements secs; tick with secs==1 -> ARMED with fails=0. Motion is ignored.
  - Code handling in EXIT_DELAY, ARMED and ALARM: a match -> DISARMED with fails=0 and secs=0. A mismatch increments fails; if the new value equals MAX_TRIES -> LOCKOUT with secs=LOCKOUT_S, otherwise the state is unchanged.
  - arm_p outside DISARMED is ignored.
- Priority in one cycle: code match > mismatch-lockout > motion > tick.
- oVideo_On = oAlarm = 1 in ALARM or LOCKOUT. Both are registered (flopped with the state), so they are valid in the same cycle oState shows the state.
- Arithmetic: secs is 8-bit and never decrements below 0. fails is 3-bit and saturates at MAX_TRIES.

Test Plan:
Bench parameters: CLK_HZ=10, DEBOUNCE_CYC=4, EXIT_DELAY_S=2, ALARM_HOLD_S=3, LOCKOUT_S=2, MAX_TRIES=3.
- Reset, then pulse iARM -> oState=1 and oSecs_Left=2. After 2 ticks -> oState=2 and oSecs_Left=0. An iSENSE toggle during EXIT_DELAY gives no alarm.
- ARMED, iSENSE 0->1 held -> oVideo_On=1 and oState=3 exactly 8 cycles after the sampling edge. With no further motion, oVideo_On=0 and oState=2 after 3 ticks.
- ARMED, iSENSE glitch of 3 cycles -> no motion event and state stays 2. A glitch of 4 cycles or more -> ALARM.
- ALARM, second motion while secs=1 coinciding with a tick -> secs=3 and state stays 3.
- ALARM, iSW=10'h112 with iENTER pulse -> oState=0, oVideo_On=0, oFails=0.
- ARMED, three iENTER pulses with iSW=10'h000 -> oFails 1,2 then oState=4 and oVideo_On=1. A correct code in LOCKOUT is ignored. After 2 ticks -> oState=2, oFails=0. Assert iRST mid-lockout -> all outputs 0 immediately.
